mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and sequencer for the Osiris I core. It shares one synchronous SRAM port between instruction fetch (IF) and data access (MEM), and inserts the programmed memory wait states. It raises a pipeline stall to the hazard logic until each requester's access completes. It sits between the datapath (`o_pc_IF` / `i_instr_IF`, `o_data_addr_M` / `o_write_data_M` / `o_mem_write_M` / `i_read_data_M`) and the external memory macro.

## Interface
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 32: address width.
- `WAIT_CYCLES`, 1: memory read latency in cycles; legal range 1..15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; one clock, asynchronous assert, active-low (0 = reset).
- `i_if_req`  in  1  fetch request; held until `o_if_valid`.
- `i_if_addr`  in  ADDR_WIDTH  fetch address; stable while `i_if_req`.
- `o_if_rdata`  out  DATA_WIDTH  fetched instruction; registered.
- `o_if_valid`  out  1  one-cycle completion pulse, fetch side.
- `i_dm_req`  in  1  data request; held until `o_dm_valid`.
- `i_dm_we`  in  1  1 = write, 0 = read.
- `i_dm_addr`  in  ADDR_WIDTH  data address.
- `i_dm_wdata`  in  DATA_WIDTH  write data.
- `o_dm_rdata`  out  DATA_WIDTH  load data; registered.
- `o_dm_valid`  out  1  one-cycle completion pulse, data side.
- `o_mem_req`  out  1  memory chip-select, one cycle per access.
- `o_mem_we`  out  1  memory write enable; qualified by `o_mem_req`.
- `o_mem_addr`  out  ADDR_WIDTH  latched address.
- `o_mem_wdata`  out  DATA_WIDTH  latched write data.
- `i_mem_rdata`  in  DATA_WIDTH  memory read data.
- `o_stall`  out  1  freeze request to the hazard unit.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs except `o_stall` are registered.
- **IDLE**
  - If `i_dm_req`: grant DM; latch `addr`, `we`, `wdata`; go to ISSUE.
  - Else if `i_if_req`: grant IF with `we` = 0; go to ISSUE.
  - Else stay in IDLE.
  - Simultaneous requests: DM always wins, because it belongs to the older instruction. IF is served on the next IDLE.
- **ISSUE**
  - `o_mem_req` = 1; `o_mem_we`, `o_mem_addr` and `o_mem_wdata` come from the latch.
  - Load the wait counter with `WAIT_CYCLES`; go to WAIT.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter reaches 1, capture `i_mem_rdata` into the granted side's rdata register (read only; a write leaves `o_dm_rdata` unchanged).
  - Go to DONE.
- **DONE**
  - Pulse the granted side's `*_valid` for one cycle; go to IDLE.
  - Requests are not sampled in DONE, so the completing request cannot be re-issued.
- `o_stall` = (`i_if_req` & ~`o_if_valid`) | (`i_dm_req` & ~`o_dm_valid`). This is combinational.
- The non-granted rdata register holds its value.
- A requester that drops `req` mid-transaction does not abort it: the access completes and `valid` still pulses.
- `o_mem_addr` and `o_mem_wdata` hold their last value outside ISSUE.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (`o_stall` follows its inputs).
- Cycle 0: IDLE samples `req`.
- Cycle 1: ISSUE, `o_mem_req` high.
- Cycle 1+W: memory data valid, captured at the end of that cycle.
- Cycle 2+W: `*_valid` high with rdata.
- Cycle 3+W: IDLE, the earliest next grant.
- Access period: W+3 cycles. With W = 1: issue at cycle 1, valid at cycle 3.
- Writes follow the same sequence; the memory commits the write at the end of the ISSUE cycle.
- Reset asserted mid-access: the access is abandoned immediately. No valid pulse is produced. A write already issued in ISSUE may have been committed.
- Pipeline contract: the requester deasserts or changes `req` in the cycle after `valid`.

## Structure
- Shared package `osiris_pkg` holds:
  - the 2-bit state encodings `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_DONE` (0..3);
  - the grant encodings `GNT_IF` = 0 and `GNT_DM` = 1.
- Single flat module; the 4-bit wait counter is inline. No sub-module is needed.

## Test plan
- Reset: hold `rst` = 0 with both requests high → all outputs 0, no `o_mem_req`. Release → DM serviced first.
- IF read, W = 1: `i_if_addr` = 0x100, memory returns 0x00500093 → `o_mem_req` at cycle 1, `o_if_valid` with rdata 0x00500093 at cycle 3. `o_stall` is high in cycles 0–2 and low in cycle 3.
- Collision: IF addr 0x104 and DM read 0x2000 raised together → DM issued first, `o_dm_valid` at cycle 3. IF issued at cycle 5, `o_if_valid` at cycle 7. `o_stall` is high until cycle 7.
- DM write, W = 3: addr 0x2004, data 0xDEADBEEF → one `o_mem_req`/`o_mem_we` pulse with those values. `o_dm_valid` at cycle 5; `o_dm_rdata` unchanged.
- Abort: assert `rst` in the WAIT state of a read → no valid pulse. After release, a new request completes normally.
- Dropped request: IF `req` falls in ISSUE → `o_if_valid` still pulses at cycle 2+W, and no second access is issued.

Source files
------------

// File: rtl/osiris_pkg.sv
// Shared encodings for the Osiris I core.
// Memory arbiter state and grant codes.
package osiris_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter: IF and MEM share one port,
// with programmable read latency and a stall to hazard logic.
module mem_arbiter
  import osiris_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  output logic                  o_if_valid,
  input  logic                  i_dm_req,
  input  logic                  i_dm_we,
  input  logic [ADDR_WIDTH-1:0] i_dm_addr,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_dm_valid,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_stall
);

  arb_state_e            state_q, state_d;
  arb_gnt_e              gnt_q, gnt_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  dm_valid_q, dm_valid_d;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        // Data side wins ties: it belongs to the older instruction.
        if (i_dm_req) begin
          gnt_d       = GNT_DM;
          mem_we_d    = i_dm_we;
          mem_addr_d  = i_dm_addr;
          mem_wdata_d = i_dm_wdata;
          mem_req_d   = 1'b1;
          state_d     = ARB_ISSUE;
        end else if (i_if_req) begin
          gnt_d      = GNT_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = i_if_addr;
          mem_req_d  = 1'b1;
          state_d    = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ARB_DONE;
          if (gnt_q == GNT_DM) begin
            dm_valid_d = 1'b1;
            if (!mem_we_q) dm_rdata_d = i_mem_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = i_mem_rdata;
          end
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      gnt_q       <= GNT_IF;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_valid_q  <= dm_valid_d;
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_valid  = if_valid_q;
  assign o_dm_rdata  = dm_rdata_q;
  assign o_dm_valid  = dm_valid_q;

  assign o_stall = (i_if_req & ~if_valid_q) | (i_dm_req & ~dm_valid_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at W=1
// with a latency-accurate SRAM model, one at W=3.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_if_req, a_dm_req, a_dm_we;
  logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata, a_mem_rdata;
  logic [31:0] a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic        a_if_valid, a_dm_valid, a_mem_req, a_mem_we, a_stall;

  logic        b_if_req, b_dm_req, b_dm_we;
  logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
  logic [31:0] b_if_rdata, b_dm_rdata, b_mem_addr, b_mem_wdata;
  logic        b_if_valid, b_dm_valid, b_mem_req, b_mem_we, b_stall;

  mem_arbiter #(.WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst),
    .i_if_req(a_if_req), .i_if_addr(a_if_addr),
    .o_if_rdata(a_if_rdata), .o_if_valid(a_if_valid),
    .i_dm_req(a_dm_req), .i_dm_we(a_dm_we),
    .i_dm_addr(a_dm_addr), .i_dm_wdata(a_dm_wdata),
    .o_dm_rdata(a_dm_rdata), .o_dm_valid(a_dm_valid),
    .o_mem_req(a_mem_req), .o_mem_we(a_mem_we),
    .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata),
    .i_mem_rdata(a_mem_rdata), .o_stall(a_stall)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst),
    .i_if_req(b_if_req), .i_if_addr(b_if_addr),
    .o_if_rdata(b_if_rdata), .o_if_valid(b_if_valid),
    .i_dm_req(b_dm_req), .i_dm_we(b_dm_we),
    .i_dm_addr(b_dm_addr), .i_dm_wdata(b_dm_wdata),
    .o_dm_rdata(b_dm_rdata), .o_dm_valid(b_dm_valid),
    .o_mem_req(b_mem_req), .o_mem_we(b_mem_we),
    .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
    .i_mem_rdata(b_mem_rdata), .o_stall(b_stall)
  );

  // SRAM model for u_a: data valid only in cycle 1+W after issue
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  int unsigned a_cnt;
  logic [31:0] a_data;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_cnt  <= 0;
      a_data <= '0;
    end else if (a_mem_req && !a_mem_we) begin
      a_cnt  <= 1;
      a_data <= mem_f(a_mem_addr);
    end else if (a_cnt != 0) begin
      a_cnt <= a_cnt - 1;
    end
  end
  assign a_mem_rdata = (a_cnt == 1) ? a_data : 32'hBAD0_0000;

  int a_nreq = 0, a_nvalid = 0, b_nreq = 0;
  always @(posedge clk) begin
    if (a_mem_req) a_nreq <= a_nreq + 1;
    if (a_if_valid) a_nvalid <= a_nvalid + 1;
    if (b_mem_req) b_nreq <= b_nreq + 1;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic samp;
    @(negedge clk);
  endtask

  int n0, nv0;

  initial begin
    rst = 1'b0;
    a_if_req = 1'b1; a_if_addr = 32'h100;
    a_dm_req = 1'b1; a_dm_we = 1'b0;
    a_dm_addr = 32'h2000; a_dm_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0;
    b_dm_req = 1'b0; b_dm_we = 1'b0;
    b_dm_addr = '0; b_dm_wdata = '0;
    b_mem_rdata = 32'h1234_5678;

    // reset with both requests high
    repeat (3) @(posedge clk);
    samp;
    chk("rst_mem_req", 32'(a_mem_req), 0);
    chk("rst_if_valid", 32'(a_if_valid), 0);
    chk("rst_dm_valid", 32'(a_dm_valid), 0);
    chk("rst_mem_addr", a_mem_addr, 0);
    chk("rst_dm_rdata", a_dm_rdata, 0);
    chk("rst_stall", 32'(a_stall), 1);
    chk("rst_b_stall", 32'(b_stall), 0);
    tick; rst = 1'b1;
    tick; samp;
    chk("rel_mem_req", 32'(a_mem_req), 1);
    chk("rel_dm_first", a_mem_addr, 32'h2000);
    tick; tick; samp;
    chk("rel_dm_valid", 32'(a_dm_valid), 1);
    chk("rel_dm_rdata", a_dm_rdata, 32'hA5A5_2000);
    chk("rel_stall", 32'(a_stall), 1);
    tick; a_dm_req = 1'b0; a_if_req = 1'b0;
    samp;
    chk("rel_idle", 32'(a_mem_req), 0);

    // IF read, W=1
    tick; a_if_req = 1'b1; a_if_addr = 32'h100;
    samp;
    chk("if0_stall", 32'(a_stall), 1);
    chk("if0_mem_req", 32'(a_mem_req), 0);
    tick; samp;
    chk("if1_mem_req", 32'(a_mem_req), 1);
    chk("if1_addr", a_mem_addr, 32'h100);
    chk("if1_we", 32'(a_mem_we), 0);
    chk("if1_stall", 32'(a_stall), 1);
    tick; samp;
    chk("if2_valid", 32'(a_if_valid), 0);
    chk("if2_mem_req", 32'(a_mem_req), 0);
    chk("if2_stall", 32'(a_stall), 1);
    tick; samp;
    chk("if3_valid", 32'(a_if_valid), 1);
    chk("if3_rdata", a_if_rdata, 32'h0050_0093);
    chk("if3_stall", 32'(a_stall), 0);
    tick; a_if_req = 1'b0;
    samp;
    chk("if4_valid", 32'(a_if_valid), 0);

    // collision: DM first, then IF
    tick;
    a_if_req = 1'b1; a_if_addr = 32'h104;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h2000;
    tick; samp;
    chk("c1_mem_req", 32'(a_mem_req), 1);
    chk("c1_addr", a_mem_addr, 32'h2000);
    tick; tick; samp;
    chk("c3_dm_valid", 32'(a_dm_valid), 1);
    chk("c3_dm_rdata", a_dm_rdata, 32'hA5A5_2000);
    chk("c3_if_valid", 32'(a_if_valid), 0);
    chk("c3_stall", 32'(a_stall), 1);
    tick; a_dm_req = 1'b0;
    samp;
    chk("c4_mem_req", 32'(a_mem_req), 0);
    chk("c4_stall", 32'(a_stall), 1);
    tick; samp;
    chk("c5_mem_req", 32'(a_mem_req), 1);
    chk("c5_addr", a_mem_addr, 32'h104);
    tick; samp;
    chk("c6_stall", 32'(a_stall), 1);
    tick; samp;
    chk("c7_if_valid", 32'(a_if_valid), 1);
    chk("c7_if_rdata", a_if_rdata, 32'hA5A5_0104);
    chk("c7_dm_hold", a_dm_rdata, 32'hA5A5_2000);
    chk("c7_stall", 32'(a_stall), 0);
    tick; a_if_req = 1'b0;

    // DM write, W=3
    tick;
    b_dm_req = 1'b1; b_dm_we = 1'b1;
    b_dm_addr = 32'h2004; b_dm_wdata = 32'hDEAD_BEEF;
    n0 = b_nreq;
    tick; samp;
    chk("w1_mem_req", 32'(b_mem_req), 1);
    chk("w1_we", 32'(b_mem_we), 1);
    chk("w1_addr", b_mem_addr, 32'h2004);
    chk("w1_wdata", b_mem_wdata, 32'hDEAD_BEEF);
    tick; samp;
    chk("w2_valid", 32'(b_dm_valid), 0);
    tick; tick; samp;
    chk("w4_valid", 32'(b_dm_valid), 0);
    chk("w4_stall", 32'(b_stall), 1);
    tick; samp;
    chk("w5_valid", 32'(b_dm_valid), 1);
    chk("w5_rdata", b_dm_rdata, 0);
    chk("w5_stall", 32'(b_stall), 0);
    tick; b_dm_req = 1'b0;
    tick; tick; samp;
    chk("w_pulses", 32'(b_nreq - n0), 1);

    // IF request dropped during ISSUE
    tick; a_if_req = 1'b1; a_if_addr = 32'h100;
    n0 = a_nreq;
    tick; a_if_req = 1'b0;
    samp;
    chk("d1_mem_req", 32'(a_mem_req), 1);
    chk("d1_stall", 32'(a_stall), 0);
    tick; tick; samp;
    chk("d3_valid", 32'(a_if_valid), 1);
    chk("d3_rdata", a_if_rdata, 32'h0050_0093);
    tick; tick; tick; samp;
    chk("d_pulses", 32'(a_nreq - n0), 1);
    chk("d6_valid", 32'(a_if_valid), 0);

    // reset in WAIT abandons the read
    tick; a_if_req = 1'b1; a_if_addr = 32'h104;
    tick; tick; samp;
    chk("ab2_mem_req", 32'(a_mem_req), 0);
    rst = 1'b0; a_if_req = 1'b0;
    nv0 = a_nvalid;
    #1;
    chk("ab_rst_valid", 32'(a_if_valid), 0);
    chk("ab_rst_rdata", a_if_rdata, 0);
    tick; tick; rst = 1'b1;
    samp;
    chk("ab_no_valid", 32'(a_nvalid - nv0), 0);
    chk("ab_mem_req", 32'(a_mem_req), 0);
    tick; a_if_req = 1'b1; a_if_addr = 32'h104;
    tick; tick; tick; samp;
    chk("ab3_valid", 32'(a_if_valid), 1);
    chk("ab3_rdata", a_if_rdata, 32'hA5A5_0104);
    tick; a_if_req = 1'b0;
    tick;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
